// File: rtl/axis_pkt_gen_pkg.sv
// Shared types for the AXI4-Stream packet generator: FSM states and
// data pattern mode encodings.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_TAG   = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: emits cfg_num_pkts packets of cfg_len beats
// with a programmable idle gap, data pattern and abort-at-boundary support.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [LEN_WIDTH-1:0]  cfg_num_pkts,
  input  logic [LEN_WIDTH-1:0]  cfg_gap,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beat_count
);

  localparam int HALF = DATA_WIDTH / 2;

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  len_q, num_q, gap_q, gap_cnt_q;
  logic [LEN_WIDTH-1:0]  beat_q, pkt_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] seed_q, run_q;
  logic                  abort_q;
  logic                  valid_q, last_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [31:0]           beat_count_q;

  logic [LEN_WIDTH-1:0]  nxt_beat_d, nxt_pkt_d, start_len_d;
  logic [DATA_WIDTH-1:0] nxt_run_d, nxt_data_d;
  logic                  nxt_last_d, hs, final_pkt;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] seed,
    input logic [DATA_WIDTH-1:0] run,
    input logic [LEN_WIDTH-1:0]  pkt,
    input logic [LEN_WIDTH-1:0]  beat
  );
    logic [DATA_WIDTH-1:0] res;
    case (mode)
      MODE_TAG:   res = {HALF'(pkt), HALF'(beat)};
      MODE_CONST: res = seed;
      default:    res = seed + run;
    endcase
    return res;
  endfunction

  assign hs          = valid_q & m_axis_ready;
  assign final_pkt   = (pkt_q == num_q - LEN_WIDTH'(1));
  assign start_len_d = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;

  // Precompute the beat that follows the current one so the output
  // registers can be loaded directly on the handshake edge.
  always_comb begin
    nxt_beat_d = beat_q + LEN_WIDTH'(1);
    nxt_pkt_d  = pkt_q;
    if (last_q) begin
      nxt_beat_d = '0;
      nxt_pkt_d  = pkt_q + LEN_WIDTH'(1);
    end
    nxt_run_d  = run_q + DATA_WIDTH'(1);
    nxt_last_d = (nxt_beat_d == len_q - LEN_WIDTH'(1));
    nxt_data_d = pattern(mode_q, seed_q, nxt_run_d, nxt_pkt_d, nxt_beat_d);
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      num_q        <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      beat_q       <= '0;
      pkt_q        <= '0;
      mode_q       <= MODE_INC;
      seed_q       <= '0;
      run_q        <= '0;
      abort_q      <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      beat_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q        <= start_len_d;
            num_q        <= cfg_num_pkts;
            gap_q        <= cfg_gap;
            mode_q       <= cfg_mode;
            seed_q       <= cfg_seed;
            beat_q       <= '0;
            pkt_q        <= '0;
            run_q        <= '0;
            abort_q      <= 1'b0;
            beat_count_q <= '0;
            busy_q       <= 1'b1;
            if (cfg_num_pkts == '0) begin
              state_q <= FIN;
            end else begin
              state_q <= SEND;
              valid_q <= 1'b1;
              data_q  <= pattern(cfg_mode, cfg_seed, '0, '0, '0);
              last_q  <= (start_len_d == LEN_WIDTH'(1));
            end
          end
        end
        SEND: begin
          if (abort) abort_q <= 1'b1;
          if (hs) begin
            beat_count_q <= beat_count_q + 32'd1;
            beat_q       <= nxt_beat_d;
            pkt_q        <= nxt_pkt_d;
            run_q        <= nxt_run_d;
            data_q       <= nxt_data_d;
            last_q       <= nxt_last_d;
            // Packet boundary: finish, idle for the gap, or run straight on.
            if (last_q) begin
              if (final_pkt || abort_q || abort) begin
                state_q <= FIN;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end else if (gap_q != '0) begin
                state_q   <= GAP;
                gap_cnt_q <= gap_q;
                valid_q   <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          if (abort || abort_q) begin
            state_q <= FIN;
            last_q  <= 1'b0;
          end else if (gap_cnt_q == LEN_WIDTH'(1)) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - LEN_WIDTH'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign m_axis_last  = last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign beat_count   = beat_count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: directed runs push expected beats,
// a negedge monitor pops and compares every handshaken beat.
module tb_axis_pkt_gen;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          axi_clk = 1'b0;
  logic          axi_reset;
  logic          start, abort;
  logic [LW-1:0] cfg_len, cfg_num_pkts, cfg_gap;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic          m_axis_valid, m_axis_last, m_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic          busy, done;
  logic [31:0]   beat_count;

  logic readyFixed = 1'b1;
  logic readyRand  = 1'b1;
  bit   randReady  = 1'b0;
  assign m_axis_ready = randReady ? readyRand : readyFixed;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t expQ[$];
  beat_t expBeat;
  int vectors     = 0;
  int miscompares = 0;

  logic          stallPrev = 1'b0;
  logic [DW-1:0] stallData;
  logic          stallLast;

  int          doneIdx;
  logic [63:0] validMask;

  axis_pkt_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .start        (start),
    .abort        (abort),
    .cfg_len      (cfg_len),
    .cfg_num_pkts (cfg_num_pkts),
    .cfg_gap      (cfg_gap),
    .cfg_mode     (cfg_mode),
    .cfg_seed     (cfg_seed),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .busy         (busy),
    .done         (done),
    .beat_count   (beat_count)
  );

  always #5 axi_clk = ~axi_clk;

  // Random backpressure source, updated just after each rising edge.
  always @(posedge axi_clk) begin
    #1 readyRand = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectBeat(input logic [DW-1:0] data, input logic last);
    expQ.push_back('{data: data, last: last});
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that a
  // stalled beat holds valid, data and last until it is accepted.
  always @(negedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      stallPrev = 1'b0;
    end else if (!axi_clk) begin
      if (stallPrev) begin
        checkOutput("hold_valid", 64'(m_axis_valid), 64'd1);
        checkOutput("hold_data", 64'(m_axis_data), 64'(stallData));
        checkOutput("hold_last", 64'(m_axis_last), 64'(stallLast));
      end
      if (m_axis_valid && m_axis_ready) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", m_axis_data);
        end else begin
          expBeat = expQ.pop_front();
          checkOutput("beat_data", 64'(m_axis_data), 64'(expBeat.data));
          checkOutput("beat_last", 64'(m_axis_last), 64'(expBeat.last));
        end
      end
      stallPrev = m_axis_valid && !m_axis_ready;
      stallData = m_axis_data;
      stallLast = m_axis_last;
    end
  end

  // Start one run, scramble cfg after acceptance, then watch until done.
  task automatic applyStimulus(input bit alignEdge, input logic [LW-1:0] len,
                               input logic [LW-1:0] pkts, input logic [LW-1:0] gap,
                               input logic [1:0] mode, input logic [DW-1:0] seed,
                               input int holdStart, input int abortAt, input int maxCycles,
                               output int dIdx, output logic [63:0] vMask);
    if (alignEdge) begin
      @(posedge axi_clk);
      #1;
    end
    cfg_len      = len;
    cfg_num_pkts = pkts;
    cfg_gap      = gap;
    cfg_mode     = mode;
    cfg_seed     = seed;
    start        = 1'b1;
    @(posedge axi_clk);
    #1;
    cfg_len      = 16'd1;
    cfg_num_pkts = 16'd7;
    cfg_gap      = 16'd2;
    cfg_mode     = ~mode;
    cfg_seed     = ~seed;
    dIdx  = -1;
    vMask = '0;
    for (int idx = 0; idx < maxCycles; idx++) begin
      @(negedge axi_clk);
      if (idx < 64 && m_axis_valid) vMask[idx] = 1'b1;
      if (idx == 0) checkOutput("busy_in_run", 64'(busy), 64'd1);
      if (idx + 1 >= holdStart) start = 1'b0;
      abort = (idx == abortAt);
      if (done) begin
        dIdx = idx;
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (dIdx < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected done", maxCycles);
    end
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    axi_reset    = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    cfg_len      = '0;
    cfg_num_pkts = '0;
    cfg_gap      = '0;
    cfg_mode     = '0;
    cfg_seed     = '0;
    repeat (2) @(negedge axi_clk);
    checkOutput("rst_valid", 64'(m_axis_valid), 64'd0);
    checkOutput("rst_last", 64'(m_axis_last), 64'd0);
    checkOutput("rst_data", 64'(m_axis_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
    @(posedge axi_clk);
    #1 axi_reset = 1'b0;

    // Back-to-back packets, full throughput.
    for (int i = 0; i < 8; i++) expectBeat(32'h10 + 32'(i), (i == 3 || i == 7));
    applyStimulus(1'b1, 16'd4, 16'd2, 16'd0, 2'd0, 32'h10, 1, -1, 100, doneIdx, validMask);
    checkOutput("inc_valid_mask", validMask, 64'hFF);
    checkOutput("inc_done_idx", 64'(doneIdx), 64'd9);
    checkOutput("inc_beat_count", 64'(beat_count), 64'd8);

    // Same run under random backpressure.
    for (int i = 0; i < 8; i++) expectBeat(32'h10 + 32'(i), (i == 3 || i == 7));
    randReady = 1'b1;
    applyStimulus(1'b1, 16'd4, 16'd2, 16'd0, 2'd0, 32'h10, 1, -1, 300, doneIdx, validMask);
    randReady = 1'b0;
    checkOutput("bp_beat_count", 64'(beat_count), 64'd8);

    // Tag mode with a 5-cycle gap.
    expectBeat(32'h0000_0000, 1'b0);
    expectBeat(32'h0000_0001, 1'b0);
    expectBeat(32'h0000_0002, 1'b1);
    expectBeat(32'h0001_0000, 1'b0);
    expectBeat(32'h0001_0001, 1'b0);
    expectBeat(32'h0001_0002, 1'b1);
    applyStimulus(1'b1, 16'd3, 16'd2, 16'd5, 2'd1, 32'hDEAD_BEEF, 1, -1, 100, doneIdx, validMask);
    checkOutput("tag_valid_mask", validMask, 64'h707);
    checkOutput("tag_done_idx", 64'(doneIdx), 64'd12);
    checkOutput("tag_beat_count", 64'(beat_count), 64'd6);

    // Abort during packet 0 lets that packet finish and stops the run.
    for (int i = 0; i < 8; i++) expectBeat(32'h100 + 32'(i), (i == 7));
    applyStimulus(1'b1, 16'd8, 16'd10, 16'd0, 2'd0, 32'h100, 1, 2, 200, doneIdx, validMask);
    checkOutput("abort_valid_mask", validMask, 64'hFF);
    checkOutput("abort_done_idx", 64'(doneIdx), 64'd9);
    checkOutput("abort_beat_count", 64'(beat_count), 64'd8);

    // Zero packets: straight to done.
    applyStimulus(1'b1, 16'd4, 16'd0, 16'd0, 2'd0, 32'h20, 1, -1, 20, doneIdx, validMask);
    checkOutput("zero_valid_mask", validMask, 64'h0);
    checkOutput("zero_done_idx", 64'(doneIdx), 64'd1);
    checkOutput("zero_beat_count", 64'(beat_count), 64'd0);

    // start held high while busy must not restart or re-latch cfg.
    for (int i = 0; i < 4; i++) expectBeat(32'h40 + 32'(i), (i == 3));
    applyStimulus(1'b1, 16'd4, 16'd1, 16'd0, 2'd0, 32'h40, 4, -1, 50, doneIdx, validMask);
    checkOutput("hold_valid_mask", validMask, 64'hF);
    checkOutput("hold_done_idx", 64'(doneIdx), 64'd5);
    checkOutput("hold_beat_count", 64'(beat_count), 64'd4);

    // cfg_len of zero means single-beat packets; constant mode.
    for (int i = 0; i < 3; i++) expectBeat(32'h0000_ABCD, 1'b1);
    applyStimulus(1'b1, 16'd0, 16'd3, 16'd0, 2'd2, 32'h0000_ABCD, 1, -1, 50, doneIdx, validMask);
    checkOutput("len0_valid_mask", validMask, 64'h7);
    checkOutput("len0_done_idx", 64'(doneIdx), 64'd4);
    checkOutput("len0_beat_count", 64'(beat_count), 64'd3);

    // Mode 3 increments like mode 0 and wraps the data width.
    expectBeat(32'hFFFF_FFFF, 1'b0);
    expectBeat(32'h0000_0000, 1'b1);
    applyStimulus(1'b1, 16'd2, 16'd1, 16'd0, 2'd3, 32'hFFFF_FFFF, 1, -1, 50, doneIdx, validMask);
    checkOutput("m3_valid_mask", validMask, 64'h3);
    checkOutput("m3_beat_count", 64'(beat_count), 64'd2);

    // Reset in the middle of a stalled packet.
    readyFixed = 1'b0;
    @(posedge axi_clk);
    #1;
    cfg_len      = 16'd4;
    cfg_num_pkts = 16'd1;
    cfg_gap      = 16'd0;
    cfg_mode     = 2'd0;
    cfg_seed     = 32'h55;
    start        = 1'b1;
    @(posedge axi_clk);
    #1 start = 1'b0;
    repeat (3) @(negedge axi_clk);
    checkOutput("stall_valid", 64'(m_axis_valid), 64'd1);
    checkOutput("stall_data", 64'(m_axis_data), 64'h55);
    #2 axi_reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(m_axis_valid), 64'd0);
    checkOutput("mid_rst_last", 64'(m_axis_last), 64'd0);
    checkOutput("mid_rst_data", 64'(m_axis_data), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_done", 64'(done), 64'd0);
    checkOutput("mid_rst_beat_count", 64'(beat_count), 64'd0);
    expQ.delete();
    @(posedge axi_clk);
    #1;
    axi_reset  = 1'b0;
    readyFixed = 1'b1;
    for (int i = 0; i < 4; i++) expectBeat(32'h55 + 32'(i), (i == 3));
    applyStimulus(1'b0, 16'd4, 16'd1, 16'd0, 2'd0, 32'h55, 1, -1, 50, doneIdx, validMask);
    checkOutput("post_rst_valid_mask", validMask, 64'hF);
    checkOutput("post_rst_done_idx", 64'(doneIdx), 64'd5);
    checkOutput("post_rst_beat_count", 64'(beat_count), 64'd4);

    repeat (2) @(negedge axi_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width (16..64).
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of length, gap and packet-count fields.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, listed first as ports:
  axi_clk  in  1  sole clock, rising edge
  axi_reset  in  1  asynchronous active-high reset
REQ-004 SHALL have the remaining ports, one per line (name  direction  width  meaning):
  start  in  1  one-cycle pulse; begins a run when idle
  abort  in  1  one-cycle pulse; end the run at the next packet boundary
  cfg_len  in  LEN_WIDTH  beats per packet
  cfg_num_pkts  in  LEN_WIDTH  packets per run
  cfg_gap  in  LEN_WIDTH  idle cycles between packets
  cfg_mode  in  2  data pattern select
  cfg_seed  in  DATA_WIDTH  pattern base value
  m_axis_valid  out  1  AXI4-Stream TVALID
  m_axis_data  out  DATA_WIDTH  AXI4-Stream TDATA
  m_axis_last  out  1  AXI4-Stream TLAST
  m_axis_ready  in  1  AXI4-Stream TREADY
  busy  out  1  high from the accepted start until done
  done  out  1  one-cycle pulse at the end of a run
  beat_count  out  32  beats handshaken since the last accepted start

Function
REQ-005 SHALL implement the FSM states IDLE, SEND, GAP and FIN.
REQ-006 IDLE + start SHALL latch all cfg_* inputs, clear beat_count and enter SEND, or enter FIN if cfg_num_pkts==0.
REQ-007 start SHALL be ignored outside IDLE, and cfg_* changes SHALL be ignored outside IDLE.
REQ-008 cfg_len==0 SHALL be treated as 1 beat.
REQ-009 All outputs SHALL be registered; m_axis_valid SHALL rise the cycle after start is accepted (latency 1).
REQ-010 Handshake rule: a beat transfers only on a cycle with m_axis_valid && m_axis_ready.
REQ-011 Once m_axis_valid is high, data, last and valid SHALL hold stable until the handshake.
REQ-012 m_axis_last SHALL be high only on beat cfg_len-1 of each packet.
REQ-013 On the last-beat handshake: if packets remain and no abort is pending, go to GAP when cfg_gap>0, otherwise stay in SEND and present the next packet's beat 0 the following cycle with valid kept high.
REQ-014 On the last-beat handshake with no packets remaining, or with abort pending, SHALL go to FIN.
REQ-015 GAP SHALL hold m_axis_valid low for exactly cfg_gap cycles, then return to SEND.
REQ-016 FIN SHALL last one cycle: done=1, busy=0 at the next edge, then IDLE.
REQ-017 abort SHALL be recorded as pending in SEND or GAP.
REQ-018 A pending abort in SEND SHALL let the current packet complete, including TLAST; in GAP it SHALL go to FIN immediately.
REQ-019 abort in IDLE or FIN SHALL be ignored; start and abort together in IDLE SHALL start the run.
REQ-020 Mode 0 (increment): data = cfg_seed + run beat index, modulo 2^DATA_WIDTH.
REQ-021 Mode 1 (tag): data upper half = packet index, lower half = beat index within the packet, each truncated to DATA_WIDTH/2.
REQ-022 Mode 2 (constant): data = cfg_seed on every beat.
REQ-023 Mode 3 SHALL behave as mode 0.
REQ-024 beat_count SHALL increment on every handshake and wrap at 2^32.
REQ-025 Packet and beat counters are LEN_WIDTH wide; cfg_len and cfg_num_pkts at their maximum value SHALL complete without overflow.

Reset
REQ-026 Asserting axi_reset at any time, including mid-packet, SHALL immediately force IDLE, clear all counters and any pending abort, and drive m_axis_valid, m_axis_last, m_axis_data, busy, done and beat_count to 0.
REQ-027 The first start SHALL be accepted on the first edge after axi_reset deasserts.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the cfg_mode encodings (MODE_INC=0, MODE_TAG=1, MODE_CONST=2).
REQ-029 The block SHALL be a single module; no sub-module.

Verification
REQ-030 len=4, pkts=2, gap=0, mode 0, seed=0x10, ready=1 -> data 0x10..0x17, last on beats 3 and 7, valid high continuously, done 1 cycle after beat 7, beat_count=8.
REQ-031 Same run with ready toggled randomly -> identical data and last sequence, data stable while valid && !ready.
REQ-032 len=3, pkts=2, gap=5, mode 1 -> data 0x00000000,1,2 then exactly 5 idle cycles, then 0x00010000,0x00010001,0x00010002.
REQ-033 len=8, pkts=10, abort pulsed at beat 2 of packet 0 -> packet 0 completes with last on beat 7, no further beats, done asserted, beat_count=8.
REQ-034 pkts=0 -> no valid beats, done 2 cycles after start; start held high while busy -> no restart.
REQ-035 axi_reset pulsed mid-packet with ready=0 -> all outputs 0 immediately, next start begins at beat 0 with seed value.
